// File: rtl/h14tx_clk_rst_seq.sv
// h14tx_clk_rst_seq: TX PLL reset/lock sequencer; releases serdes then pixel resets once lock is stable.
// Latency: 2-cycle lock synchronizer; all outputs registered, following the state register by zero cycles.
// Backpressure: none; restart/lock loss force PLL_RESET, retry budget exhaustion parks in FAULT.
module h14tx_clk_rst_seq #(
  parameter int ResetCycles       = 16,
  parameter int LockTimeoutCycles = 70000,
  parameter int StableCycles      = 7000,
  parameter int SerdesDelayCycles = 8,
  parameter int MaxRetries        = 4
) (
  input  logic       ref_clk_70mhz,
  input  logic       rst,
  input  logic       pll_lock_async,
  input  logic       restart,
  output logic       pll_rst_n,
  output logic       serdes_rst,
  output logic       pixel_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] relock_count,
  output logic [2:0] state
);

  localparam int MaxA = (ResetCycles > LockTimeoutCycles) ? ResetCycles : LockTimeoutCycles;
  localparam int MaxB = (StableCycles > SerdesDelayCycles) ? StableCycles : SerdesDelayCycles;
  localparam int MaxP = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int CntW = $clog2(MaxP) + 1;
  localparam int RetW = $clog2(MaxRetries + 2);

  localparam logic [CntW-1:0] RstLast  = CntW'(ResetCycles - 1);
  localparam logic [CntW-1:0] LockLast = CntW'(LockTimeoutCycles - 1);
  localparam logic [CntW-1:0] StabLast = CntW'(StableCycles - 1);
  localparam logic [CntW-1:0] SerLast  = CntW'(SerdesDelayCycles - 1);
  localparam logic [RetW-1:0] RetMax   = RetW'(MaxRetries);

  typedef enum logic [2:0] {
    PLL_RESET  = 3'd0,
    WAIT_LOCK  = 3'd1,
    DEBOUNCE   = 3'd2,
    SERDES_REL = 3'd3,
    RUN        = 3'd4,
    FAULT      = 3'd5
  } state_t;

  logic            r_lock_meta;
  logic            r_lock_s;
  state_t          r_state;
  logic [CntW-1:0] r_cnt;
  logic [RetW-1:0] r_retry;
  logic [7:0]      r_relock;
  logic            r_pll_rst_n;
  logic            r_serdes_rst;
  logic            r_pixel_rst;
  logic            r_ready;
  logic            r_fault;
  logic [RetW-1:0] w_retry_inc;

  assign w_retry_inc = r_retry + 1'b1;

  // Two-flop synchronizer bringing the PLL lock into the reference clock domain
  always_ff @(posedge ref_clk_70mhz) begin
    if (rst) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock_async;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Sequencer FSM: next state chosen first, then counter and outputs registered from it
  always_ff @(posedge ref_clk_70mhz) begin : fsm
    state_t v_nxt;
    logic   v_clr;
    if (rst) begin
      r_state      <= PLL_RESET;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_relock     <= '0;
      r_pll_rst_n  <= 1'b0;
      r_serdes_rst <= 1'b1;
      r_pixel_rst  <= 1'b1;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      v_nxt = r_state;
      v_clr = 1'b0;
      if (restart) begin
        // Restart reruns the whole sequence even from PLL_RESET, so force a counter clear
        v_nxt = PLL_RESET;
        v_clr = 1'b1;
        r_retry <= '0;
      end else begin
        unique case (r_state)
          PLL_RESET: begin
            if (r_cnt == RstLast) v_nxt = WAIT_LOCK;
          end
          WAIT_LOCK: begin
            if (r_lock_s) begin
              v_nxt = DEBOUNCE;
            end else if (r_cnt == LockLast) begin
              r_retry <= w_retry_inc;
              v_nxt = ((MaxRetries != 0) && (w_retry_inc == RetMax)) ? FAULT : PLL_RESET;
            end
          end
          DEBOUNCE: begin
            if (!r_lock_s) begin
              v_nxt = WAIT_LOCK;
            end else if (r_cnt == StabLast) begin
              v_nxt = SERDES_REL;
              r_retry <= '0;
            end
          end
          SERDES_REL: begin
            // Lock loss is checked first so it beats a coincident timed exit
            if (!r_lock_s) v_nxt = PLL_RESET;
            else if (r_cnt == SerLast) v_nxt = RUN;
          end
          RUN: begin
            if (!r_lock_s) begin
              v_nxt = PLL_RESET;
              if (r_relock != 8'hFF) r_relock <= r_relock + 8'd1;
            end
          end
          FAULT: v_nxt = FAULT;
          default: v_nxt = PLL_RESET;
        endcase
        v_clr = (v_nxt != r_state);
      end
      r_state <= v_nxt;
      // Untimed states hold the counter so it never wraps into a false match
      if (v_clr) r_cnt <= '0;
      else if (r_state != RUN && r_state != FAULT) r_cnt <= r_cnt + 1'b1;
      r_pll_rst_n  <= (v_nxt != PLL_RESET) && (v_nxt != FAULT);
      r_serdes_rst <= (v_nxt == PLL_RESET) || (v_nxt == WAIT_LOCK) ||
                      (v_nxt == DEBOUNCE) || (v_nxt == FAULT);
      r_pixel_rst  <= (v_nxt != RUN);
      r_ready      <= (v_nxt == RUN);
      r_fault      <= (v_nxt == FAULT);
    end
  end

  assign pll_rst_n    = r_pll_rst_n;
  assign serdes_rst   = r_serdes_rst;
  assign pixel_rst    = r_pixel_rst;
  assign ready        = r_ready;
  assign fault        = r_fault;
  assign relock_count = r_relock;
  assign state        = r_state;

endmodule

// File: tb/tb_h14tx_clk_rst_seq.sv
// tb_h14tx_clk_rst_seq: directed bring-up/bounce/timeout/relock scenarios plus random lock traffic.
// Every cycle the full output bundle is compared against a behavioural sequencer model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_h14tx_clk_rst_seq;
  localparam int RC = 4;
  localparam int LT = 50;
  localparam int SC = 10;
  localparam int SD = 3;
  localparam int MR = 2;

  localparam int P_RESET = 0;
  localparam int P_WAIT  = 1;
  localparam int P_DEB   = 2;
  localparam int P_SER   = 3;
  localparam int P_RUN   = 4;
  localparam int P_FAULT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst_n, serdes_rst, pixel_rst, ready, fault;
  logic [7:0] relock_count;
  logic [2:0] state;

  int n_chk = 0;
  int n_fail = 0;

  // behavioural model: phase, time spent in phase, retries, relock tally, lock pipeline
  int   m_ph = P_RESET;
  int   m_age = 0;
  int   m_retry = 0;
  int   m_relock = 0;
  logic m_q0 = 1'b0;
  logic m_q1 = 1'b0;

  h14tx_clk_rst_seq #(
    .ResetCycles(RC), .LockTimeoutCycles(LT), .StableCycles(SC),
    .SerdesDelayCycles(SD), .MaxRetries(MR)
  ) dut (
    .ref_clk_70mhz(clk), .rst(rst), .pll_lock_async(lock), .restart(restart),
    .pll_rst_n(pll_rst_n), .serdes_rst(serdes_rst), .pixel_rst(pixel_rst),
    .ready(ready), .fault(fault), .relock_count(relock_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic enter(input int ph);
    m_ph  = ph;
    m_age = 0;
  endtask

  // One reference-clock edge of the sequencer, using the inputs present at that edge
  task automatic model_edge();
    logic ls;
    ls   = m_q0;
    m_q0 = m_q1;
    m_q1 = lock;
    if (rst) begin
      enter(P_RESET);
      m_retry = 0; m_relock = 0; m_q0 = 1'b0; m_q1 = 1'b0;
    end else if (restart) begin
      enter(P_RESET);
      m_retry = 0;
    end else begin
      case (m_ph)
        P_RESET: if (m_age == RC - 1) enter(P_WAIT); else m_age++;
        P_WAIT: begin
          if (ls) enter(P_DEB);
          else if (m_age == LT - 1) begin
            m_retry++;
            if (MR != 0 && m_retry == MR) enter(P_FAULT); else enter(P_RESET);
          end else m_age++;
        end
        P_DEB: begin
          if (!ls) enter(P_WAIT);
          else if (m_age == SC - 1) begin m_retry = 0; enter(P_SER); end
          else m_age++;
        end
        P_SER: if (!ls) enter(P_RESET); else if (m_age == SD - 1) enter(P_RUN); else m_age++;
        P_RUN: if (!ls) begin
          if (m_relock < 255) m_relock++;
          enter(P_RESET);
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [15:0] exp_outs();
    logic prn, srs, prs, rdy, flt;
    prn = !(m_ph == P_RESET || m_ph == P_FAULT);
    srs = (m_ph == P_RESET || m_ph == P_WAIT || m_ph == P_DEB || m_ph == P_FAULT);
    prs = (m_ph != P_RUN);
    rdy = (m_ph == P_RUN);
    flt = (m_ph == P_FAULT);
    return {prn, srs, prs, rdy, flt, 8'(m_relock), 3'(m_ph)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("outs", {pll_rst_n, serdes_rst, pixel_rst, ready, fault, relock_count, state}, exp_outs());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (ready !== 1'b1 && n < budget) begin tick(); n++; end
    if (ready !== 1'b1) check("ready_timeout", ready, 1);
  endtask

  task automatic wait_serdes_rel(input int budget, output int n);
    n = 0;
    while (serdes_rst !== 1'b0 && n < budget) begin tick(); n++; end
    if (serdes_rst !== 1'b0) check("serdes_timeout", serdes_rst, 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int seg;
    int rl_before;

    // 1. Nominal bring-up
    ticks(3);
    check("rst_pll_rst_n", pll_rst_n, 0);
    check("rst_pixel_rst", pixel_rst, 1);
    rst = 1'b0;
    n = 0;
    while (pll_rst_n !== 1'b1 && n < 100) begin tick(); n++; end
    check("pll_rst_n_rise", n, RC);
    ticks(20 - n);
    lock = 1'b1;
    wait_serdes_rel(100, n);
    check("lock_to_serdes", n, 2 + 1 + SC);
    wait_ready(100, n);
    check("serdes_to_ready", n, SD);
    check("fault_nominal", fault, 0);

    // 2. Lock bounce during debounce
    lock = 1'b0;
    pulse_rst();
    ticks(8);
    lock = 1'b1; ticks(5);
    lock = 1'b0; ticks(1);
    lock = 1'b1;
    wait_ready(200, n);
    check("bounce_to_ready", n, 3 + SC + SD);

    // 3. Lock timeout, fault, restart
    lock = 1'b0;
    pulse_rst();
    n = 0;
    while (fault !== 1'b1 && n < 400) begin tick(); n++; end
    check("cycles_to_fault", n, MR * (RC + LT));
    check("fault_pll_rst_n", pll_rst_n, 0);
    ticks(5);
    check("fault_held", fault, 1);
    restart = 1'b1; tick(); restart = 1'b0;
    check("restart_fault", fault, 0);
    check("restart_state", state, P_RESET);
    lock = 1'b1;
    wait_ready(200, n);

    // 4. Lock loss in RUN, then saturation
    lock = 1'b0;
    n = 0;
    while (pixel_rst !== 1'b1 && n < 20) begin tick(); n++; end
    check("loss_to_reset", n, 3);
    check("loss_pll_rst_n", pll_rst_n, 0);
    check("relock_1", relock_count, 1);
    lock = 1'b1;
    for (int k = 0; k < 300; k++) begin
      wait_ready(200, n);
      lock = 1'b0; ticks(3); lock = 1'b1;
    end
    check("relock_sat", relock_count, 255);

    // 5. Lock loss coinciding with the serdes-release exit
    wait_serdes_rel(200, n);
    lock = 1'b0;
    rl_before = relock_count;
    ticks(5);
    check("ser_loss_relock", relock_count, rl_before);
    check("ser_loss_serdes_rst", serdes_rst, 1);
    check("ser_loss_ready", ready, 0);
    lock = 1'b1;
    wait_ready(200, n);

    // 6. Reset while running
    pulse_rst();
    check("midrst_relock", relock_count, 0);
    check("midrst_state", state, P_RESET);
    check("midrst_serdes", serdes_rst, 1);

    // 7. Random lock traffic with occasional restart and reset
    seg = 1;
    for (int c = 0; c < 4000; c++) begin
      seg--;
      if (seg == 0) begin
        lock = ~lock;
        seg = lock ? $urandom_range(1, 70) : $urandom_range(1, 30);
      end
      restart = ($urandom_range(0, 149) == 0);
      rst     = ($urandom_range(0, 399) == 0);
      tick();
    end
    restart = 1'b0;
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
